// File: rtl/alu_branch_pkg.sv
// Shared constants for the ALU/branch execution slice: default datapath width
// and the branch condition codes carried in IR[20:19].
package alu_branch_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

endpackage

// File: rtl/con_ff_logic.sv
// CON flip-flop: decodes the branch condition against the bus value and latches the result.
// Latency: result visible on branch_met one cycle after con_in is sampled.
// Backpressure: none; inputs are sampled unconditionally at the clock edge.
module con_ff_logic
    import alu_branch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [3:0]       cond,
    input  logic             con_in,
    output logic             branch_met
);

    logic bus_zero;
    logic bus_neg;
    logic taken;

    // Only the low two condition bits select a test; the upper pair is don't-care.
    logic unused_cond_hi;
    assign unused_cond_hi = ^cond[3:2];

    assign bus_zero = (bus_in == '0);
    assign bus_neg  = bus_in[WIDTH-1];

    always_comb begin
        taken = 1'b0;
        case (cond[1:0])
            COND_ZR: taken = bus_zero;
            COND_NZ: taken = !bus_zero;
            COND_PL: taken = !bus_neg;
            COND_MI: taken = bus_neg;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            branch_met <= 1'b0;
        end else if (con_in) begin
            branch_met <= taken;
        end
    end

endmodule

// File: rtl/alu_branch_unit.sv
// ALU slice: Y AND/ADD(/OR when ALU_BRANCH_OR_EN) bus into 64-bit Z, plus the CON branch flag.
// Latency: one cycle from operands/selects to zhi/zlo and branch_met.
// Backpressure: none; z_in/con_in are plain load enables sampled at the clock edge.
module alu_branch_unit
    import alu_branch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             carry_in,
    input  logic             op_and,
`ifdef ALU_BRANCH_OR_EN
    input  logic             op_or,
`endif
    input  logic             op_add,
    input  logic             z_in,
    input  logic [3:0]       cond,
    input  logic             con_in,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo,
    output logic             branch_met
);

    logic [WIDTH-1:0] and_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] z_hi_nxt;
    logic [WIDTH-1:0] z_lo_nxt;
    logic             z_sel_vld;

    assign and_res = y_in & bus_in;
    assign sum     = {1'b0, y_in} + {1'b0, bus_in} + {{WIDTH{1'b0}}, carry_in};

    // Priority select; with no op selected the Z register keeps its value even if z_in is high.
    always_comb begin
        z_hi_nxt  = '0;
        z_lo_nxt  = '0;
        z_sel_vld = 1'b0;
        if (op_and) begin
            z_lo_nxt  = and_res;
            z_sel_vld = 1'b1;
        end
`ifdef ALU_BRANCH_OR_EN
        else if (op_or) begin
            z_lo_nxt  = y_in | bus_in;
            z_sel_vld = 1'b1;
        end
`endif
        else if (op_add) begin
            z_lo_nxt  = sum[WIDTH-1:0];
            z_hi_nxt  = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            z_sel_vld = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            zhi <= '0;
            zlo <= '0;
        end else if (z_in && z_sel_vld) begin
            zhi <= z_hi_nxt;
            zlo <= z_lo_nxt;
        end
    end

    con_ff_logic #(
        .WIDTH (WIDTH)
    ) u_con_ff (
        .Clock      (Clock),
        .Clear      (Clear),
        .bus_in     (bus_in),
        .cond       (cond),
        .con_in     (con_in),
        .branch_met (branch_met)
    );

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed-vector bench for alu_branch_unit; expected values are hand-computed constants.
module tb_alu_branch_unit;

    logic        Clock;
    logic        Clear;
    logic [31:0] y_in;
    logic [31:0] bus_in;
    logic        carry_in;
    logic        op_and;
    logic        op_add;
`ifdef ALU_BRANCH_OR_EN
    logic        op_or;
`endif
    logic        z_in;
    logic [3:0]  cond;
    logic        con_in;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        branch_met;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    alu_branch_unit #(.WIDTH(32)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .y_in       (y_in),
        .bus_in     (bus_in),
        .carry_in   (carry_in),
        .op_and     (op_and),
`ifdef ALU_BRANCH_OR_EN
        .op_or      (op_or),
`endif
        .op_add     (op_add),
        .z_in       (z_in),
        .cond       (cond),
        .con_in     (con_in),
        .zhi        (zhi),
        .zlo        (zlo),
        .branch_met (branch_met)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs are set ~1ns after an edge; outputs are sampled 1ns after the next edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_z(input logic a, input logic ad, input logic [31:0] y,
                         input logic [31:0] b, input logic ci, input logic zl);
        op_and = a; op_add = ad; y_in = y; bus_in = b; carry_in = ci; z_in = zl;
    endtask

    task automatic set_con(input logic [3:0] c, input logic [31:0] b, input logic cl);
        cond = c; bus_in = b; con_in = cl;
    endtask

    initial begin
        Clear = 1'b0; y_in = '0; bus_in = '0; carry_in = 1'b0;
        op_and = 1'b0; op_add = 1'b0; z_in = 1'b0; cond = 4'h0; con_in = 1'b0;
`ifdef ALU_BRANCH_OR_EN
        op_or = 1'b0;
`endif
        #2;

        // Reset overrides load enables; bus=0 with brzr would otherwise set the flag
        set_z(1'b0, 1'b1, 32'h5, 32'h0, 1'b1, 1'b1);
        cond = 4'h0; con_in = 1'b1;
        tick();
        chk("rst_zhi", zhi, 32'h0);
        chk("rst_zlo", zlo, 32'h0);
        chk("rst_bm", {31'b0, branch_met}, 32'h0);

        Clear = 1'b1; con_in = 1'b0;
        set_z(1'b1, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b1);
        tick();
        chk("and_zlo", zlo, 32'h00F0_000F);
        chk("and_zhi", zhi, 32'h0);
        chk("and_bm_hold", {31'b0, branch_met}, 32'h0);

        set_z(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
        tick();
        chk("add_co_zlo", zlo, 32'h0000_0001);
        chk("add_co_zhi", zhi, 32'h0000_0001);

        set_z(1'b0, 1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
        tick();
        chk("add_ci_zlo", zlo, 32'd13);
        chk("add_ci_zhi", zhi, 32'h0);

        set_z(1'b1, 1'b1, 32'h3, 32'h5, 1'b0, 1'b1);
        tick();
        chk("prio_zlo", zlo, 32'h1);
        chk("prio_zhi", zhi, 32'h0);

        set_z(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0);
        tick();
        chk("zhold_zlo", zlo, 32'h1);

        set_z(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        chk("nosel_zlo", zlo, 32'h1);
        chk("nosel_zhi", zhi, 32'h0);

        z_in = 1'b0;
        set_con(4'b0000, 32'h0, 1'b1);
        tick();
        chk("brzr_0", {31'b0, branch_met}, 32'h1);
        set_con(4'b0001, 32'h0, 1'b1);
        tick();
        chk("brnz_0", {31'b0, branch_met}, 32'h0);
        set_con(4'b0010, 32'h8000_0000, 1'b1);
        tick();
        chk("brpl_neg", {31'b0, branch_met}, 32'h0);
        set_con(4'b0011, 32'h8000_0000, 1'b1);
        tick();
        chk("brmi_neg", {31'b0, branch_met}, 32'h1);
        set_con(4'b0001, 32'h0, 1'b0);
        tick();
        chk("con_hold", {31'b0, branch_met}, 32'h1);
        set_con(4'b0010, 32'h0, 1'b1);
        tick();
        chk("brpl_zero", {31'b0, branch_met}, 32'h1);
        set_con(4'b1100, 32'h5, 1'b1);
        tick();
        chk("brzr_hi_ign", {31'b0, branch_met}, 32'h0);
        set_con(4'b1110, 32'h7FFF_FFFF, 1'b1);
        tick();
        chk("brpl_hi_ign", {31'b0, branch_met}, 32'h1);

        // Z and CON loading on the same edge
        set_z(1'b0, 1'b1, 32'd10, 32'd20, 1'b0, 1'b1);
        cond = 4'b0000; con_in = 1'b1;
        tick();
        chk("dual_zlo", zlo, 32'd30);
        chk("dual_bm", {31'b0, branch_met}, 32'h0);

        set_con(4'b0001, 32'h0000_0040, 1'b1);
        set_z(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0040, 1'b1, 1'b1);
        tick();
        chk("pre_rst_bm", {31'b0, branch_met}, 32'h1);
        chk("pre_rst_zhi", zhi, 32'h1);

        Clear = 1'b0;
        tick();
        chk("mid_rst_zlo", zlo, 32'h0);
        chk("mid_rst_zhi", zhi, 32'h0);
        chk("mid_rst_bm", {31'b0, branch_met}, 32'h0);

        Clear = 1'b1;
        tick();
        chk("post_rst_zlo", zlo, 32'h0000_0031);
        chk("post_rst_zhi", zhi, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
